rob: RTL and testbench

Reorder buffer directly downstream of `dispatch`: 16 entries, indexed by the 4-bit ROB tag that `dispatch` attaches to every RS entry (`*_entry_num`). Per cycle it allocates up to two entries in program order, accepts up to two execution-unit writebacks by tag, and retires up to two completed entries in order from the head to the register file. It owns `rob_head`/`rob_tail`, which feed `dispatch`'s full check.

---
 rtl/rob_if.sv | 54 +++++
 rtl/rob.sv | 159 +++++++++++++++
 tb/tb_rob.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rob_if.sv
// rob_if: groups the reorder buffer's control/data signals.
//   master : the dispatch/execute side. It drives flush, the allocate requests
//            and the writebacks, and receives the pointers, status and commits.
//   slave  : the reorder buffer itself.
// Parameters: DATA_W = result width, RD_W = destination register index width.
interface rob_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              flush;
  logic              alloc_a_valid;
  logic [RD_W-1:0]   alloc_a_rd;
  logic              alloc_a_regwrite;
  logic              alloc_b_valid;
  logic [RD_W-1:0]   alloc_b_rd;
  logic              alloc_b_regwrite;
  logic              wb0_valid;
  logic [3:0]        wb0_tag;
  logic [DATA_W-1:0] wb0_data;
  logic              wb1_valid;
  logic [3:0]        wb1_tag;
  logic [DATA_W-1:0] wb1_data;
  logic [3:0]        rob_head;
  logic [3:0]        rob_tail;
  logic [4:0]        rob_count;
  logic              rob_empty;
  logic              alloc_err;
  logic              commit0_valid;
  logic [RD_W-1:0]   commit0_rd;
  logic [DATA_W-1:0] commit0_data;
  logic              commit0_regwrite;
  logic              commit1_valid;
  logic [RD_W-1:0]   commit1_rd;
  logic [DATA_W-1:0] commit1_data;
  logic              commit1_regwrite;

  modport master (
    output flush, alloc_a_valid, alloc_a_rd, alloc_a_regwrite,
           alloc_b_valid, alloc_b_rd, alloc_b_regwrite,
           wb0_valid, wb0_tag, wb0_data, wb1_valid, wb1_tag, wb1_data,
    input  rob_head, rob_tail, rob_count, rob_empty, alloc_err,
           commit0_valid, commit0_rd, commit0_data, commit0_regwrite,
           commit1_valid, commit1_rd, commit1_data, commit1_regwrite
  );

  modport slave (
    input  flush, alloc_a_valid, alloc_a_rd, alloc_a_regwrite,
           alloc_b_valid, alloc_b_rd, alloc_b_regwrite,
           wb0_valid, wb0_tag, wb0_data, wb1_valid, wb1_tag, wb1_data,
    output rob_head, rob_tail, rob_count, rob_empty, alloc_err,
           commit0_valid, commit0_rd, commit0_data, commit0_regwrite,
           commit1_valid, commit1_rd, commit1_data, commit1_regwrite
  );
endinterface

// File: rtl/rob.sv
// rob: 16-entry reorder buffer (capacity 15; one slot is always left empty).
// Each cycle it allocates up to two entries in program order at the tail,
// accepts up to two writebacks by tag, and retires up to two completed
// entries in order from the head.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, equivalent to a flush
//   bus   : rob_if.slave. Carries flush, alloc A/B, wb0/wb1, head/tail/count,
//           empty, alloc_err and commit0/commit1.
module rob #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  rob_if.slave bus
);
  localparam int N = 16;

  logic [3:0]        head_q, head_d, tail_q, tail_d;
  logic [4:0]        count_q, count_d;
  logic [N-1:0]      busy_q, busy_d, done_q, done_d;

  // Payload storage. It has no reset because busy/done qualify every entry.
  logic [RD_W-1:0]   rd_mem [N];
  logic [DATA_W-1:0] data_mem [N];
  logic [N-1:0]      regwrite_mem;

  logic              c0_valid_q, c0_valid_d, c1_valid_q, c1_valid_d;
  logic [RD_W-1:0]   c0_rd_q, c0_rd_d, c1_rd_q, c1_rd_d;
  logic [DATA_W-1:0] c0_data_q, c0_data_d, c1_data_q, c1_data_d;
  logic              c0_rw_q, c0_rw_d, c1_rw_q, c1_rw_d;
  logic              alloc_err_q, alloc_err_d;

  logic [3:0] head1;
  logic       c0, c1;
  logic [1:0] commit_n, alloc_n;
  logic       fit1, fit2, a_acc, b_acc;
  logic [3:0] a_idx, b_idx;
  logic       wb0_hit, wb1_hit;

  // Commit decision on the pre-edge state. The second slot only retires
  // behind the first, so retirement stays in order.
  assign head1    = head_q + 4'd1;
  assign c0       = busy_q[head_q] & done_q[head_q] & ~bus.flush;
  assign c1       = c0 & busy_q[head1] & done_q[head1];
  assign commit_n = {1'b0, c0} + {1'b0, c1};

  // Acceptance uses the pre-edge count. A slot freed by a commit on this
  // same edge therefore cannot be reused until the next cycle.
  assign fit1  = (count_q + 5'd1) <= 5'd15;
  assign fit2  = (count_q + 5'd2) <= 5'd15;
  assign a_acc = bus.alloc_a_valid & fit1 & ~bus.flush;
  assign b_acc = bus.alloc_b_valid & (bus.alloc_a_valid ? fit2 : fit1) & ~bus.flush;
  assign a_idx = tail_q;
  assign b_idx = bus.alloc_a_valid ? tail_q + 4'd1 : tail_q;
  assign alloc_n = {1'b0, a_acc} + {1'b0, b_acc};

  assign wb0_hit = bus.wb0_valid & busy_q[bus.wb0_tag] & ~bus.flush;
  assign wb1_hit = bus.wb1_valid & busy_q[bus.wb1_tag] & ~bus.flush;

  // Per-entry next state. Allocation only ever targets non-busy slots, so it
  // cannot collide with a writeback or a commit on the same entry.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
      localparam logic [3:0] IDX = 4'(gi);
      logic wb_set, clr, set;
      assign wb_set = (wb0_hit && bus.wb0_tag == IDX) || (wb1_hit && bus.wb1_tag == IDX);
      assign clr    = (c0 && head_q == IDX) || (c1 && head1 == IDX);
      assign set    = (a_acc && a_idx == IDX) || (b_acc && b_idx == IDX);
      assign busy_d[gi] = ~bus.flush & (set | (busy_q[gi] & ~clr));
      assign done_d[gi] = ~bus.flush & ~set & ~clr & (done_q[gi] | wb_set);
    end
  endgenerate

  always_comb begin
    head_d      = head_q + {2'b00, commit_n};
    tail_d      = tail_q + {2'b00, alloc_n};
    count_d     = count_q + {3'b000, alloc_n} - {3'b000, commit_n};
    alloc_err_d = ~bus.flush &
                  ((bus.alloc_a_valid & ~a_acc) | (bus.alloc_b_valid & ~b_acc));
    c0_valid_d  = c0;
    c0_rd_d     = c0 ? rd_mem[head_q] : '0;
    c0_data_d   = c0 ? data_mem[head_q] : '0;
    c0_rw_d     = c0 & regwrite_mem[head_q];
    c1_valid_d  = c1;
    c1_rd_d     = c1 ? rd_mem[head1] : '0;
    c1_data_d   = c1 ? data_mem[head1] : '0;
    c1_rw_d     = c1 & regwrite_mem[head1];
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      alloc_err_q <= 1'b0;
      c0_valid_q  <= 1'b0;
      c0_rd_q     <= '0;
      c0_data_q   <= '0;
      c0_rw_q     <= 1'b0;
      c1_valid_q  <= 1'b0;
      c1_rd_q     <= '0;
      c1_data_q   <= '0;
      c1_rw_q     <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      alloc_err_q <= alloc_err_d;
      c0_valid_q  <= c0_valid_d;
      c0_rd_q     <= c0_rd_d;
      c0_data_q   <= c0_data_d;
      c0_rw_q     <= c0_rw_d;
      c1_valid_q  <= c1_valid_d;
      c1_rd_q     <= c1_rd_d;
      c1_data_q   <= c1_data_d;
      c1_rw_q     <= c1_rw_d;
    end
  end

  // Payload writes. Port 1 is written last, so it wins when both ports hit
  // the same tag.
  always_ff @(posedge clk) begin
    if (wb0_hit) data_mem[bus.wb0_tag] <= bus.wb0_data;
    if (wb1_hit) data_mem[bus.wb1_tag] <= bus.wb1_data;
    if (a_acc) begin
      rd_mem[a_idx]       <= bus.alloc_a_rd;
      regwrite_mem[a_idx] <= bus.alloc_a_regwrite;
    end
    if (b_acc) begin
      rd_mem[b_idx]       <= bus.alloc_b_rd;
      regwrite_mem[b_idx] <= bus.alloc_b_regwrite;
    end
  end

  assign bus.rob_head         = head_q;
  assign bus.rob_tail         = tail_q;
  assign bus.rob_count        = count_q;
  assign bus.rob_empty        = (count_q == 5'd0);
  assign bus.alloc_err        = alloc_err_q;
  assign bus.commit0_valid    = c0_valid_q;
  assign bus.commit0_rd       = c0_rd_q;
  assign bus.commit0_data     = c0_data_q;
  assign bus.commit0_regwrite = c0_rw_q;
  assign bus.commit1_valid    = c1_valid_q;
  assign bus.commit1_rd       = c1_rd_q;
  assign bus.commit1_data     = c1_data_q;
  assign bus.commit1_regwrite = c1_rw_q;
endmodule

// File: tb/tb_rob.sv
module tb_rob;
  logic clk;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  rob_if #(.DATA_W(32), .RD_W(5)) bus ();

  rob #(.DATA_W(32), .RD_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic av, input logic [4:0] ard, input logic arw,
                           input logic bv, input logic [4:0] brd, input logic brw);
    bus.alloc_a_valid = av; bus.alloc_a_rd = ard; bus.alloc_a_regwrite = arw;
    bus.alloc_b_valid = bv; bus.alloc_b_rd = brd; bus.alloc_b_regwrite = brw;
  endtask

  task automatic set_wb(input logic v0, input logic [3:0] t0, input logic [31:0] d0,
                        input logic v1, input logic [3:0] t1, input logic [31:0] d1);
    bus.wb0_valid = v0; bus.wb0_tag = t0; bus.wb0_data = d0;
    bus.wb1_valid = v1; bus.wb1_tag = t1; bus.wb1_data = d1;
  endtask

  task automatic idle();
    bus.flush = 1'b0;
    set_alloc(0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #12;
    total_cnt++; if (bus.rob_count !== 5'd0) $display("FAIL reset_count got %0d exp 0", bus.rob_count); else pass_cnt++;
    total_cnt++; if (bus.rob_empty !== 1'b1) $display("FAIL reset_empty got %0b exp 1", bus.rob_empty); else pass_cnt++;
    total_cnt++; if (bus.rob_head !== 4'd0 || bus.rob_tail !== 4'd0) $display("FAIL reset_ptr got h%0d t%0d exp h0 t0", bus.rob_head, bus.rob_tail); else pass_cnt++;
    total_cnt++; if (bus.commit0_valid !== 1'b0 || bus.alloc_err !== 1'b0) $display("FAIL reset_pulses got c0=%0b err=%0b exp 0 0", bus.commit0_valid, bus.alloc_err); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    set_alloc(1, 5'd3, 1, 1, 5'd7, 1);
    tick();
    set_alloc(0, 0, 0, 0, 0, 0);
    total_cnt++; if (bus.rob_tail !== 4'd2) $display("FAIL basic_tail got %0d exp 2", bus.rob_tail); else pass_cnt++;
    total_cnt++; if (bus.rob_count !== 5'd2) $display("FAIL basic_count got %0d exp 2", bus.rob_count); else pass_cnt++;
    set_wb(1, 4'd1, 32'hBB, 0, 0, 0);
    tick();
    total_cnt++; if (bus.commit0_valid !== 1'b0) $display("FAIL basic_no_early_commit got %0b exp 0", bus.commit0_valid); else pass_cnt++;
    set_wb(1, 4'd0, 32'hAA, 0, 0, 0);
    tick();
    set_wb(0, 0, 0, 0, 0, 0);
    total_cnt++; if (bus.commit0_valid !== 1'b0) $display("FAIL basic_no_bypass got %0b exp 0", bus.commit0_valid); else pass_cnt++;
    tick();
    total_cnt++; if (bus.commit0_valid !== 1'b1 || bus.commit0_rd !== 5'd3 || bus.commit0_data !== 32'hAA) $display("FAIL basic_commit0 got v%0b rd%0d d%0h exp v1 rd3 dAA", bus.commit0_valid, bus.commit0_rd, bus.commit0_data); else pass_cnt++;
    total_cnt++; if (bus.commit1_valid !== 1'b1 || bus.commit1_rd !== 5'd7 || bus.commit1_data !== 32'hBB) $display("FAIL basic_commit1 got v%0b rd%0d d%0h exp v1 rd7 dBB", bus.commit1_valid, bus.commit1_rd, bus.commit1_data); else pass_cnt++;
    total_cnt++; if (bus.rob_head !== 4'd2 || bus.rob_count !== 5'd0) $display("FAIL basic_head_count got h%0d c%0d exp h2 c0", bus.rob_head, bus.rob_count); else pass_cnt++;
    tick();
    total_cnt++; if (bus.commit0_valid !== 1'b0 || bus.commit1_data !== 32'h0) $display("FAIL basic_pulse got v%0b d%0h exp v0 d0", bus.commit0_valid, bus.commit1_data); else pass_cnt++;
    $display("test_basic: done");
  endtask

  task automatic test_full();
    do_flush();
    for (int i = 0; i < 7; i++) begin
      set_alloc(1, 5'd1, 1, 1, 5'd2, 1);
      tick();
    end
    total_cnt++; if (bus.rob_count !== 5'd14 || bus.rob_tail !== 4'd14 || bus.alloc_err !== 1'b0) $display("FAIL full_fill got c%0d t%0d err%0b exp c14 t14 err0", bus.rob_count, bus.rob_tail, bus.alloc_err); else pass_cnt++;
    tick();
    total_cnt++; if (bus.rob_count !== 5'd15 || bus.rob_tail !== 4'd15 || bus.alloc_err !== 1'b1) $display("FAIL full_partial got c%0d t%0d err%0b exp c15 t15 err1", bus.rob_count, bus.rob_tail, bus.alloc_err); else pass_cnt++;
    tick();
    set_alloc(0, 0, 0, 0, 0, 0);
    total_cnt++; if (bus.rob_count !== 5'd15 || bus.rob_tail !== 4'd15 || bus.alloc_err !== 1'b1) $display("FAIL full_drop got c%0d t%0d err%0b exp c15 t15 err1", bus.rob_count, bus.rob_tail, bus.alloc_err); else pass_cnt++;
    tick();
    total_cnt++; if (bus.alloc_err !== 1'b0) $display("FAIL full_err_pulse got %0b exp 0", bus.alloc_err); else pass_cnt++;
    $display("test_full: done");
  endtask

  task automatic test_wrap();
    do_flush();
    for (int i = 0; i < 7; i++) begin
      set_alloc(1, 5'd1, 1, 1, 5'd2, 1);
      tick();
    end
    set_alloc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      set_wb(1, 4'(2 * i), 32'h1, 1, 4'(2 * i + 1), 32'h2);
      tick();
    end
    set_wb(0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    total_cnt++; if (bus.rob_head !== 4'd14 || bus.rob_tail !== 4'd14 || bus.rob_count !== 5'd0) $display("FAIL wrap_setup got h%0d t%0d c%0d exp h14 t14 c0", bus.rob_head, bus.rob_tail, bus.rob_count); else pass_cnt++;
    set_alloc(1, 5'd30, 1, 1, 5'd29, 1);
    tick();
    total_cnt++; if (bus.rob_tail !== 4'd0 || bus.rob_count !== 5'd2) $display("FAIL wrap_tail0 got t%0d c%0d exp t0 c2", bus.rob_tail, bus.rob_count); else pass_cnt++;
    set_alloc(1, 5'd28, 1, 1, 5'd27, 0);
    tick();
    set_alloc(0, 0, 0, 0, 0, 0);
    total_cnt++; if (bus.rob_tail !== 4'd2 || bus.rob_count !== 5'd4) $display("FAIL wrap_tail2 got t%0d c%0d exp t2 c4", bus.rob_tail, bus.rob_count); else pass_cnt++;
    set_wb(1, 4'd14, 32'h140, 1, 4'd15, 32'h150);
    tick();
    set_wb(1, 4'd0, 32'h100, 1, 4'd1, 32'h101);
    tick();
    set_wb(0, 0, 0, 0, 0, 0);
    total_cnt++; if (bus.commit0_rd !== 5'd30 || bus.commit0_data !== 32'h140 || bus.commit1_rd !== 5'd29 || bus.commit1_data !== 32'h150) $display("FAIL wrap_commit_14_15 got rd%0d d%0h rd%0d d%0h exp rd30 d140 rd29 d150", bus.commit0_rd, bus.commit0_data, bus.commit1_rd, bus.commit1_data); else pass_cnt++;
    total_cnt++; if (bus.rob_head !== 4'd0) $display("FAIL wrap_head0 got %0d exp 0", bus.rob_head); else pass_cnt++;
    tick();
    total_cnt++; if (bus.commit0_rd !== 5'd28 || bus.commit0_data !== 32'h100 || bus.commit1_rd !== 5'd27 || bus.commit1_data !== 32'h101) $display("FAIL wrap_commit_0_1 got rd%0d d%0h rd%0d d%0h exp rd28 d100 rd27 d101", bus.commit0_rd, bus.commit0_data, bus.commit1_rd, bus.commit1_data); else pass_cnt++;
    total_cnt++; if (bus.commit1_regwrite !== 1'b0 || bus.commit0_regwrite !== 1'b1) $display("FAIL wrap_regwrite got %0b %0b exp 1 0", bus.commit0_regwrite, bus.commit1_regwrite); else pass_cnt++;
    total_cnt++; if (bus.rob_head !== 4'd2 || bus.rob_count !== 5'd0) $display("FAIL wrap_final got h%0d c%0d exp h2 c0", bus.rob_head, bus.rob_count); else pass_cnt++;
    $display("test_wrap: done");
  endtask

  task automatic test_same_tag();
    set_alloc(1, 5'd2, 1, 1, 5'd3, 0);
    tick();
    set_alloc(1, 5'd4, 1, 1, 5'd5, 1);
    tick();
    set_alloc(0, 0, 0, 0, 0, 0);
    total_cnt++; if (bus.rob_tail !== 4'd6 || bus.rob_count !== 5'd4) $display("FAIL same_setup got t%0d c%0d exp t6 c4", bus.rob_tail, bus.rob_count); else pass_cnt++;
    set_wb(1, 4'd5, 32'h11, 1, 4'd5, 32'h22);
    tick();
    set_wb(1, 4'd2, 32'h20, 1, 4'd3, 32'h30);
    tick();
    set_wb(1, 4'd4, 32'h40, 1, 4'd9, 32'h99);
    tick();
    set_wb(0, 0, 0, 0, 0, 0);
    total_cnt++; if (bus.commit0_rd !== 5'd2 || bus.commit0_data !== 32'h20 || bus.commit1_rd !== 5'd3 || bus.commit1_data !== 32'h30) $display("FAIL same_commit_2_3 got rd%0d d%0h rd%0d d%0h exp rd2 d20 rd3 d30", bus.commit0_rd, bus.commit0_data, bus.commit1_rd, bus.commit1_data); else pass_cnt++;
    total_cnt++; if (bus.rob_count !== 5'd2) $display("FAIL same_nonbusy_wb got c%0d exp 2", bus.rob_count); else pass_cnt++;
    tick();
    total_cnt++; if (bus.commit1_valid !== 1'b1 || bus.commit1_rd !== 5'd5 || bus.commit1_data !== 32'h22) $display("FAIL same_port1_wins got v%0b rd%0d d%0h exp v1 rd5 d22", bus.commit1_valid, bus.commit1_rd, bus.commit1_data); else pass_cnt++;
    total_cnt++; if (bus.rob_head !== 4'd6 || bus.rob_tail !== 4'd6 || bus.rob_count !== 5'd0) $display("FAIL same_final got h%0d t%0d c%0d exp h6 t6 c0", bus.rob_head, bus.rob_tail, bus.rob_count); else pass_cnt++;
    $display("test_same_tag: done");
  endtask

  task automatic test_flush();
    set_alloc(1, 5'd1, 1, 1, 5'd2, 1);
    tick();
    set_alloc(1, 5'd3, 1, 0, 0, 0);
    tick();
    set_alloc(0, 0, 0, 0, 0, 0);
    total_cnt++; if (bus.rob_count !== 5'd3 || bus.rob_tail !== 4'd9) $display("FAIL flush_setup got c%0d t%0d exp c3 t9", bus.rob_count, bus.rob_tail); else pass_cnt++;
    set_wb(1, 4'd6, 32'h66, 0, 0, 0);
    tick();
    bus.flush = 1'b1;
    set_alloc(1, 5'd4, 1, 1, 5'd5, 1);
    set_wb(1, 4'd7, 32'h77, 0, 0, 0);
    tick();
    idle();
    total_cnt++; if (bus.rob_count !== 5'd0 || bus.rob_head !== 4'd0 || bus.rob_tail !== 4'd0) $display("FAIL flush_state got c%0d h%0d t%0d exp c0 h0 t0", bus.rob_count, bus.rob_head, bus.rob_tail); else pass_cnt++;
    total_cnt++; if (bus.commit0_valid !== 1'b0 || bus.alloc_err !== 1'b0 || bus.rob_empty !== 1'b1) $display("FAIL flush_outputs got c0=%0b err=%0b empty=%0b exp 0 0 1", bus.commit0_valid, bus.alloc_err, bus.rob_empty); else pass_cnt++;
    tick();
    total_cnt++; if (bus.commit0_valid !== 1'b0 || bus.rob_count !== 5'd0) $display("FAIL flush_after got c0=%0b c%0d exp 0 0", bus.commit0_valid, bus.rob_count); else pass_cnt++;
    $display("test_flush: done");
  endtask

  task automatic test_async_reset();
    set_alloc(1, 5'd9, 1, 1, 5'd10, 1);
    tick();
    set_alloc(0, 0, 0, 0, 0, 0);
    set_wb(1, 4'd0, 32'h55, 0, 0, 0);
    tick();
    set_wb(0, 0, 0, 0, 0, 0);
    tick();
    total_cnt++; if (bus.commit0_valid !== 1'b1 || bus.commit0_data !== 32'h55 || bus.rob_count !== 5'd1) $display("FAIL arst_pre got v%0b d%0h c%0d exp v1 d55 c1", bus.commit0_valid, bus.commit0_data, bus.rob_count); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.rob_count !== 5'd0 || bus.rob_empty !== 1'b1) $display("FAIL arst_count got c%0d empty%0b exp c0 empty1", bus.rob_count, bus.rob_empty); else pass_cnt++;
    total_cnt++; if (bus.commit0_valid !== 1'b0 || bus.commit0_data !== 32'h0 || bus.commit0_rd !== 5'd0) $display("FAIL arst_commit got v%0b d%0h rd%0d exp 0 0 0", bus.commit0_valid, bus.commit0_data, bus.commit0_rd); else pass_cnt++;
    total_cnt++; if (bus.rob_head !== 4'd0 || bus.rob_tail !== 4'd0) $display("FAIL arst_ptr got h%0d t%0d exp h0 t0", bus.rob_head, bus.rob_tail); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total_cnt++; if (bus.rob_count !== 5'd0 || bus.commit1_valid !== 1'b0) $display("FAIL arst_after got c%0d c1v%0b exp 0 0", bus.rob_count, bus.commit1_valid); else pass_cnt++;
    $display("test_async_reset: done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_same_tag();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
